sram_mem_ctrl: RTL and testbench



---
 rtl/sram_mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: connects the pipeline memory stage to a 16-bit asynchronous SRAM.
// A DATA_W word access is split into 16-bit beats, beat 0 = least significant
// halfword, and each beat is held on the bus for WAIT_CYC cycles. The SRAM-side
// strobes, address and data are registered so the SRAM sees glitch-free control.
// `ready` is combinational so the pipeline freezes in the same cycle a request appears.
module sram_mem_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WAIT_CYC  = 1,
    parameter int unsigned BASE_ADDR = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N
);

    localparam int unsigned BEATS      = DATA_W / 16;
    localparam int unsigned BEAT_W     = $clog2(BEATS) + 1;
    localparam int unsigned WAIT_W     = $clog2(WAIT_CYC) + 1;
    localparam int unsigned WORD_SHIFT = $clog2(DATA_W / 8);
    localparam int unsigned LAST_BEAT  = BEATS - 1;
    localparam int unsigned LAST_WAIT  = WAIT_CYC - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [17:0]         base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                is_wr_q, is_wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [17:0]         sram_addr_q, sram_addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                we_n_q, we_n_d;

    logic                req;
    logic [31:0]         word_idx;
    logic [17:0]         req_base;
    logic                load_beat;
    logic                op_wr;
    logic [DATA_W-1:0]   op_data;
    logic [17:0]         op_base;

    // Request decode and SRAM word base of the incoming address
    always_comb begin
        req      = wr_en | rd_en;
        word_idx = 32'(addr - 32'(BASE_ADDR)) >> WORD_SHIFT;
        req_base = 18'(word_idx * 32'(BEATS));
    end

    // State register and all registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    // Next state, beat/wait sequencing, read capture and next-cycle bus values
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        load_beat   = 1'b0;
        op_wr       = is_wr_q;
        op_data     = wdata_q;
        op_base     = base_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d   = ST_ACCESS;
                    beat_d    = '0;
                    wait_d    = '0;
                    base_d    = req_base;
                    wdata_d   = wdata;
                    is_wr_d   = wr_en;
                    load_beat = 1'b1;
                    op_wr     = wr_en;
                    op_data   = wdata;
                    op_base   = req_base;
                end
            end
            ST_ACCESS: begin
                if (wait_q == WAIT_W'(LAST_WAIT)) begin
                    // Last cycle of the beat: SRAM read data is settled here
                    if (!is_wr_q) begin
                        rdata_d[int'(beat_q) * 16 +: 16] = SRAM_DQ;
                    end
                    if (beat_q == BEAT_W'(LAST_BEAT)) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d    = beat_q + BEAT_W'(1);
                        wait_d    = '0;
                        load_beat = 1'b1;
                    end
                end else begin
                    wait_d    = wait_q + WAIT_W'(1);
                    load_beat = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus values for the cycle that follows this edge while a beat is active;
        // WE_N rises in the beat's last cycle so address/data are stable at the edge
        if (load_beat) begin
            sram_addr_d = op_base + 18'(beat_d);
            dq_out_d    = op_data[int'(beat_d) * 16 +: 16];
            dq_oe_d     = op_wr;
            we_n_d      = !(op_wr && ((WAIT_CYC == 1) || (wait_d != WAIT_W'(LAST_WAIT))));
        end
    end

    // Handshake and SRAM pin mapping
    always_comb begin
        ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
        rdata     = rdata_q;
        SRAM_ADDR = sram_addr_q;
        SRAM_WE_N = we_n_q;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
    end

    assign SRAM_DQ = dq_oe_q ? dq_out_q : 16'bz;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: a 32-bit/1-wait and a 64-bit/3-wait instance, each
// with a behavioural SRAM. Expected read data, bus traces and ready patterns are
// queued when stimulus is issued and popped as the DUT produces them.
module tb_sram_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: DATA_W=32, WAIT_CYC=1
    logic        wr_a = 1'b0, rd_a = 1'b0, mdl_a = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
    logic        ready_a, we_n_a, ub_a, lb_a, ce_a, oe_a;
    logic [17:0] sram_addr_a;
    wire  [15:0] dq_a;
    logic [15:0] mem_a [0:255] = '{default: 16'h0};

    // Instance B: DATA_W=64, WAIT_CYC=3
    logic        wr_b = 1'b0, rd_b = 1'b0, mdl_b = 1'b0;
    logic [31:0] addr_b = '0;
    logic [63:0] wdata_b = '0, rdata_b;
    logic        ready_b, we_n_b, ub_b, lb_b, ce_b, oe_b;
    logic [17:0] sram_addr_b;
    wire  [15:0] dq_b;
    logic [15:0] mem_b [0:255] = '{default: 16'h0};

    logic [63:0] exp_rd_q  [$];
    logic [18:0] exp_tr_q  [$];
    logic        exp_rdy_q [$];
    logic [31:0] mdl_rdata_a = '0;

    sram_mem_ctrl #(.DATA_W(32), .WAIT_CYC(1), .BASE_ADDR(1024)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a),
        .SRAM_ADDR(sram_addr_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a),
        .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .SRAM_WE_N(we_n_a)
    );

    sram_mem_ctrl #(.DATA_W(64), .WAIT_CYC(3), .BASE_ADDR(1024)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b),
        .SRAM_ADDR(sram_addr_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b),
        .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .SRAM_WE_N(we_n_b)
    );

    // SRAM models: drive read data only while the bench has issued a read
    assign dq_a = mdl_a ? mem_a[sram_addr_a[7:0]] : 16'bz;
    assign dq_b = mdl_b ? mem_b[sram_addr_b[7:0]] : 16'bz;

    always @(posedge clk) begin
        if (!we_n_a) mem_a[sram_addr_a[7:0]] <= dq_a;
        if (!we_n_b) mem_b[sram_addr_b[7:0]] <= dq_b;
    end

    // Expected SRAM_ADDR/WE_N trace of one 64-bit, 3-wait access
    task automatic push_trace_b(input logic wr, input logic [31:0] a);
        logic [31:0] base;
        base = ((a - 32'd1024) >> 3) * 32'd4;
        for (int bt = 0; bt < 4; bt++) begin
            for (int w = 0; w < 3; w++) begin
                exp_tr_q.push_back({(wr ? (w == 2) : 1'b1), 18'(base + 32'(bt))});
            end
        end
    endtask

    task automatic access_a(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input int exp_low);
        int low;
        logic [63:0] er;
        @(negedge clk);
        wr_a = wr; rd_a = rd; addr_a = a; wdata_a = d; mdl_a = rd & ~wr;
        #1;
        low = 0;
        while (!ready_a && low < 200) begin
            low++;
            @(negedge clk);
            wr_a = 1'b0; rd_a = 1'b0;
            #1;
        end
        total++;
        if (low !== exp_low) begin
            bad++;
            $display("FAIL latency_a: ready low %0d cycles, required %0d", low, exp_low);
        end
        if (rd) begin
            er = exp_rd_q.pop_front();
            total++;
            if (rdata_a !== er[31:0]) begin
                bad++;
                $display("FAIL rdata_a: got %h required %h", rdata_a, er[31:0]);
            end
        end
        mdl_a = 1'b0;
    endtask

    task automatic access_b(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [63:0] d, input int exp_low);
        int low;
        logic [18:0] tr;
        logic [63:0] er;
        @(negedge clk);
        wr_b = wr; rd_b = rd; addr_b = a; wdata_b = d; mdl_b = rd & ~wr;
        #1;
        low = 0;
        while (!ready_b && low < 200) begin
            low++;
            @(negedge clk);
            wr_b = 1'b0; rd_b = 1'b0;
            #1;
            if (!ready_b) begin
                total++;
                if (exp_tr_q.size() == 0) begin
                    bad++;
                    $display("FAIL trace_b: extra access cycle addr=%0d we_n=%b, required none",
                             sram_addr_b, we_n_b);
                end else begin
                    tr = exp_tr_q.pop_front();
                    if ({we_n_b, sram_addr_b} !== tr) begin
                        bad++;
                        $display("FAIL trace_b: addr=%0d we_n=%b required addr=%0d we_n=%b",
                                 sram_addr_b, we_n_b, tr[17:0], tr[18]);
                    end
                end
            end
        end
        total++;
        if (low !== exp_low) begin
            bad++;
            $display("FAIL latency_b: ready low %0d cycles, required %0d", low, exp_low);
        end
        total++;
        if (exp_tr_q.size() !== 0) begin
            bad++;
            $display("FAIL trace_b_len: %0d beat cycles missing, required 0", exp_tr_q.size());
            exp_tr_q.delete();
        end
        if (rd) begin
            er = exp_rd_q.pop_front();
            total++;
            if (rdata_b !== er) begin
                bad++;
                $display("FAIL rdata_b: got %h required %h", rdata_b, er);
            end
        end
        mdl_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({ready_a, ready_b, we_n_a, we_n_b} !== 4'b1111) begin
                bad++;
                $display("FAIL reset_ctl: ready=%b%b we_n=%b%b required 1111",
                         ready_a, ready_b, we_n_a, we_n_b);
            end
            total++;
            if (rdata_a !== 32'h0 || rdata_b !== 64'h0) begin
                bad++;
                $display("FAIL reset_rdata: a=%h b=%h required 0", rdata_a, rdata_b);
            end
            total++;
            if (sram_addr_a !== 18'h0 || sram_addr_b !== 18'h0) begin
                bad++;
                $display("FAIL reset_addr: a=%h b=%h required 0", sram_addr_a, sram_addr_b);
            end
        end
        total++;
        if ({ub_a, lb_a, ce_a, oe_a, ub_b, lb_b, ce_b, oe_b} !== 8'h00) begin
            bad++;
            $display("FAIL tie_offs: got %b required 00000000",
                     {ub_a, lb_a, ce_a, oe_a, ub_b, lb_b, ce_b, oe_b});
        end
    endtask

    task automatic test_rw_32();
        access_a(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 3);
        total++;
        if (mem_a[0] !== 16'hBEEF || mem_a[1] !== 16'hDEAD) begin
            bad++;
            $display("FAIL mem_a_0_1: got %h %h required beef dead", mem_a[0], mem_a[1]);
        end
        exp_rd_q.push_back(64'hDEADBEEF);
        access_a(1'b0, 1'b1, 32'd1024, 32'h0, 3);
        mdl_rdata_a = 32'hDEADBEEF;
    endtask

    task automatic test_rw_64();
        push_trace_b(1'b1, 32'd1032);
        access_b(1'b1, 1'b0, 32'd1032, 64'h0123456789ABCDEF, 13);
        total++;
        if ({mem_b[7], mem_b[6], mem_b[5], mem_b[4]} !== 64'h0123456789ABCDEF) begin
            bad++;
            $display("FAIL mem_b_4_7: got %h%h%h%h required 0123456789abcdef",
                     mem_b[7], mem_b[6], mem_b[5], mem_b[4]);
        end
        push_trace_b(1'b0, 32'd1032);
        exp_rd_q.push_back(64'h0123456789ABCDEF);
        access_b(1'b0, 1'b1, 32'd1032, 64'h0, 13);
    endtask

    task automatic test_both_en();
        exp_rd_q.push_back({32'h0, mdl_rdata_a});
        access_a(1'b1, 1'b1, 32'd1028, 32'h11112222, 3);
        total++;
        if (mem_a[2] !== 16'h2222 || mem_a[3] !== 16'h1111) begin
            bad++;
            $display("FAIL mem_a_2_3: got %h %h required 2222 1111", mem_a[2], mem_a[3]);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        wr_b = 1'b1; addr_b = 32'd1040; wdata_b = 64'hAAAA5555CCCC3333;
        @(negedge clk);
        wr_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({ready_b, we_n_b} !== 2'b11) begin
            bad++;
            $display("FAIL mid_reset_ctl: ready=%b we_n=%b required 1 1", ready_b, we_n_b);
        end
        total++;
        if (rdata_b !== 64'h0 || rdata_a !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_rdata: a=%h b=%h required 0", rdata_a, rdata_b);
        end
        rst = 1'b0;
        mdl_rdata_a = 32'h0;
        push_trace_b(1'b0, 32'd1032);
        exp_rd_q.push_back(64'h0123456789ABCDEF);
        access_b(1'b0, 1'b1, 32'd1032, 64'h0, 13);
    endtask

    task automatic test_back_to_back();
        logic er_rdy;
        logic [63:0] er;
        logic prev_rdy;
        int dones;
        for (int i = 0; i < 10; i++) exp_rdy_q.push_back(i == 3 || i >= 7);
        exp_rd_q.push_back(64'h11112222);
        exp_rd_q.push_back(64'h11112222);
        dones = 0;
        prev_rdy = 1'b1;
        @(negedge clk);
        rd_a = 1'b1; addr_a = 32'd1028; mdl_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 8) rd_a = 1'b0;
            #1;
            er_rdy = exp_rdy_q.pop_front();
            total++;
            if (ready_a !== er_rdy) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: got %b required %b", i, ready_a, er_rdy);
            end
            if (ready_a && !prev_rdy && i < 8) begin
                dones++;
                er = exp_rd_q.pop_front();
                total++;
                if (rdata_a !== er[31:0]) begin
                    bad++;
                    $display("FAIL b2b_rdata: got %h required %h", rdata_a, er[31:0]);
                end
            end
            prev_rdy = ready_a;
        end
        mdl_a = 1'b0;
        total++;
        if (dones !== 2) begin
            bad++;
            $display("FAIL b2b_count: %0d accesses, required 2", dones);
        end
        exp_rd_q.delete();
    endtask

    initial begin
        test_reset();
        test_rw_32();
        test_rw_64();
        test_both_en();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
